// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and helpers for the pipeline hazard/forwarding controller
//
// Contents:
//   fwd_sel_e     EX operand source select (regfile / MEM ALU result / WB data)
//   ctrl_act_e    per-cycle pipeline action chosen by the hazard priority logic
//   stage_info_t  tracker record for one pipeline stage {valid, rd, we, load}
//   ex_info_t     EX tracker: stage_info_t plus source indices and use bits
//   src_hit()     does a source operand read the register a stage will write
//   fwd_pick()    forwarding select for one EX operand
package pipe_ctrl_pkg;

    // Tracker structs are sized by this; the top's REG_AW must keep this value.
    localparam int PIPE_REG_AW = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        ACT_NORMAL  = 2'd0,
        ACT_MEMWAIT = 2'd1,
        ACT_BRANCH  = 2'd2,
        ACT_LOADUSE = 2'd3
    } ctrl_act_e;

    typedef struct packed {
        logic                   valid;
        logic [PIPE_REG_AW-1:0] rd;
        logic                   we;
        logic                   load;
    } stage_info_t;

    typedef struct packed {
        stage_info_t            info;
        logic [PIPE_REG_AW-1:0] rs1;
        logic [PIPE_REG_AW-1:0] rs2;
        logic                   use_rs1;
        logic                   use_rs2;
    } ex_info_t;

    // x0 is hardwired zero, so a write to it never produces a dependency.
    function automatic logic src_hit(input logic                   use_src,
                                     input logic [PIPE_REG_AW-1:0] src,
                                     input stage_info_t            st);
        return use_src & st.valid & st.we & (st.rd != '0) & (st.rd == src);
    endfunction

    // MEM is the younger producer and wins. A MEM-stage load has no data yet;
    // the load-use stall keeps that case from ever reaching EX.
    function automatic fwd_sel_e fwd_pick(input logic                   use_src,
                                          input logic [PIPE_REG_AW-1:0] src,
                                          input stage_info_t            mem,
                                          input stage_info_t            wb);
        fwd_sel_e sel;
        sel = FWD_RF;
        if (src_hit(use_src, src, mem) && !mem.load) begin
            sel = FWD_MEM;
        end else if (src_hit(use_src, src, wb)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating event counter for pipeline performance statistics
//
// Ports:
//   clk_i  in   1      clock
//   clr_i  in   1      synchronous clear (takes priority over inc_i)
//   inc_i  in   1      count one event this cycle
//   cnt_o  out  CNT_W  current count, sticks at all-ones
module pipe_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - registered hazard/forwarding controller for a 5-stage RV32I pipeline
//
// Tracks {valid, rd, we, load} of the EX, MEM and WB instructions (EX also keeps
// its sources) and derives stalls, flushes and EX operand forward selects.
// Priority: data-memory wait > taken branch/jump > load-use > normal advance.
//
// Macro: PIPE_PERF_CNT_EN - when defined, three saturating perf counters are
// built; otherwise the counter ports are tied to zero.
//
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   id_valid_i .. id_load_i         ID instruction: valid, sources, use bits, rd, we, load
//   br_taken_i                      EX resolved a taken branch/jump
//   mem_req_i, mem_ready_i          MEM data access and its completion
//   stall_if/id/ex/mem_o            hold PC / IF-ID / ID-EX / EX-MEM registers
//   flush_id/ex/wb_o                bubble into IF-ID / ID-EX / MEM-WB registers
//   fwd_a_o, fwd_b_o                EX operand source (fwd_sel_e)
//   stall_cnt_o, flush_cnt_o, memwait_cnt_o   perf counters
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = PIPE_REG_AW,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_we_i,
    input  logic              id_load_i,
    input  logic              br_taken_i,
    input  logic              mem_req_i,
    input  logic              mem_ready_i,
    output logic              stall_if_o,
    output logic              stall_id_o,
    output logic              stall_ex_o,
    output logic              stall_mem_o,
    output logic              flush_id_o,
    output logic              flush_ex_o,
    output logic              flush_wb_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
    output logic [CNT_W-1:0]  memwait_cnt_o
);

    ex_info_t    r_ex;
    stage_info_t r_mem;
    stage_info_t r_wb;

    logic        w_mem_wait;
    logic        w_load_use;
    ctrl_act_e   w_act;
    ex_info_t    w_id_info;

    assign w_mem_wait = mem_req_i & ~mem_ready_i;
    assign w_load_use = id_valid_i & r_ex.info.load &
                        (src_hit(id_use_rs1_i, id_rs1_i, r_ex.info) |
                         src_hit(id_use_rs2_i, id_rs2_i, r_ex.info));

    // A bubble carries no write, so an invalid ID slot is zeroed as a whole.
    always_comb begin
        w_id_info = '0;
        if (id_valid_i) begin
            w_id_info.info.valid = 1'b1;
            w_id_info.info.rd    = id_rd_i;
            w_id_info.info.we    = id_we_i;
            w_id_info.info.load  = id_load_i;
            w_id_info.rs1        = id_rs1_i;
            w_id_info.rs2        = id_rs2_i;
            w_id_info.use_rs1    = id_use_rs1_i;
            w_id_info.use_rs2    = id_use_rs2_i;
        end
    end

    always_comb begin
        w_act = ACT_NORMAL;
        if (w_mem_wait) begin
            w_act = ACT_MEMWAIT;
        end else if (br_taken_i) begin
            w_act = ACT_BRANCH;
        end else if (w_load_use) begin
            w_act = ACT_LOADUSE;
        end
    end

    always_comb begin
        stall_if_o  = 1'b0;
        stall_id_o  = 1'b0;
        stall_ex_o  = 1'b0;
        stall_mem_o = 1'b0;
        flush_id_o  = 1'b0;
        flush_ex_o  = 1'b0;
        flush_wb_o  = 1'b0;
        fwd_a_o     = fwd_pick(r_ex.use_rs1, r_ex.rs1, r_mem, r_wb);
        fwd_b_o     = fwd_pick(r_ex.use_rs2, r_ex.rs2, r_mem, r_wb);
        if (rst_i) begin
            // Bubbles everywhere while reset is held so nothing retires.
            flush_id_o = 1'b1;
            flush_ex_o = 1'b1;
            flush_wb_o = 1'b1;
            fwd_a_o    = FWD_RF;
            fwd_b_o    = FWD_RF;
        end else begin
            unique case (w_act)
                ACT_MEMWAIT: begin
                    stall_if_o  = 1'b1;
                    stall_id_o  = 1'b1;
                    stall_ex_o  = 1'b1;
                    stall_mem_o = 1'b1;
                    flush_wb_o  = 1'b1;
                end
                ACT_BRANCH: begin
                    flush_id_o = 1'b1;
                    flush_ex_o = 1'b1;
                end
                ACT_LOADUSE: begin
                    stall_if_o = 1'b1;
                    stall_id_o = 1'b1;
                    flush_ex_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // EX is held during a memory wait, so a pending taken branch is still
    // asserted by EX and gets acted on the cycle the wait drops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            unique case (w_act)
                ACT_MEMWAIT: begin
                    r_wb <= '0;
                end
                ACT_BRANCH, ACT_LOADUSE: begin
                    r_wb  <= r_mem;
                    r_mem <= r_ex.info;
                    r_ex  <= '0;
                end
                default: begin
                    r_wb  <= r_mem;
                    r_mem <= r_ex.info;
                    r_ex  <= w_id_info;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (w_act == ACT_LOADUSE),
        .cnt_o (stall_cnt_o)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (w_act == ACT_BRANCH),
        .cnt_o (flush_cnt_o)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_memwait_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (w_act == ACT_MEMWAIT),
        .cnt_o (memwait_cnt_o)
    );
`else
    assign stall_cnt_o   = '0;
    assign flush_cnt_o   = '0;
    assign memwait_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - cycle-by-cycle vector bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int CW = 2;  // narrow counters so saturation is reached quickly

    localparam logic [6:0] C_N  = 7'b0000_000;  // {stall_if,id,ex,mem, flush_id,ex,wb}
    localparam logic [6:0] C_RS = 7'b0000_111;
    localparam logic [6:0] C_LU = 7'b1100_010;
    localparam logic [6:0] C_BR = 7'b0000_110;
    localparam logic [6:0] C_MW = 7'b1111_001;

    logic          clk;
    logic          rst;
    logic          id_valid;
    logic [4:0]    id_rs1, id_rs2, id_rd;
    logic          id_use_rs1, id_use_rs2, id_we, id_load;
    logic          br_taken, mem_req, mem_ready;
    logic          stall_if, stall_id, stall_ex, stall_mem;
    logic          flush_id, flush_ex, flush_wb;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt, flush_cnt, memwait_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic       idv;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       br;
        logic       mrq;
        logic       mrdy;
        logic [6:0] ctl;
        int         fa;
        int         fb;
        int         sc;
        int         fc;
        int         mc;
    } vec_t;

    vec_t vecs[$];

    pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(CW)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .id_valid_i    (id_valid),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_use_rs1_i  (id_use_rs1),
        .id_use_rs2_i  (id_use_rs2),
        .id_rd_i       (id_rd),
        .id_we_i       (id_we),
        .id_load_i     (id_load),
        .br_taken_i    (br_taken),
        .mem_req_i     (mem_req),
        .mem_ready_i   (mem_ready),
        .stall_if_o    (stall_if),
        .stall_id_o    (stall_id),
        .stall_ex_o    (stall_ex),
        .stall_mem_o   (stall_mem),
        .flush_id_o    (flush_id),
        .flush_ex_o    (flush_ex),
        .flush_wb_o    (flush_wb),
        .fwd_a_o       (fwd_a),
        .fwd_b_o       (fwd_b),
        .stall_cnt_o   (stall_cnt),
        .flush_cnt_o   (flush_cnt),
        .memwait_cnt_o (memwait_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(input string n, input bit r, input bit idv,
                               input int rs1, input int rs2, input bit u1, input bit u2,
                               input int rd, input bit we, input bit ld,
                               input bit br, input bit mrq, input bit mrdy,
                               input logic [6:0] ctl, input int fa, input int fb,
                               input int sc, input int fc, input int mc);
        vec_t t;
        t.name = n;   t.rst = r;     t.idv = idv;
        t.rs1  = rs1[4:0]; t.rs2 = rs2[4:0]; t.rd = rd[4:0];
        t.u1   = u1;  t.u2 = u2;     t.we = we;   t.ld = ld;
        t.br   = br;  t.mrq = mrq;   t.mrdy = mrdy;
        t.ctl  = ctl; t.fa = fa;     t.fb = fb;
        t.sc   = sc;  t.fc = fc;     t.mc = mc;
        return t;
    endfunction

    task automatic chk(input string vn, input string what, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s %s: got 0x%0h expected 0x%0h", vn, what, act, exp);
        end
    endtask

    task automatic run(input vec_t t);
        logic [6:0] ctl;
        logic       bad;
        rst        = t.rst;  id_valid   = t.idv;
        id_rs1     = t.rs1;  id_rs2     = t.rs2;
        id_use_rs1 = t.u1;   id_use_rs2 = t.u2;
        id_rd      = t.rd;   id_we      = t.we;  id_load = t.ld;
        br_taken   = t.br;   mem_req    = t.mrq; mem_ready = t.mrdy;
        @(negedge clk);
        ctl = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb};
        chk(t.name, "ctl", int'(ctl), int'(t.ctl));
        chk(t.name, "fwd_a", int'(fwd_a), t.fa);
        chk(t.name, "fwd_b", int'(fwd_b), t.fb);
`ifdef PIPE_PERF_CNT_EN
        chk(t.name, "stall_cnt", int'(stall_cnt), t.sc);
        chk(t.name, "flush_cnt", int'(flush_cnt), t.fc);
        chk(t.name, "memwait_cnt", int'(memwait_cnt), t.mc);
`else
        chk(t.name, "stall_cnt", int'(stall_cnt), 0);
        chk(t.name, "flush_cnt", int'(flush_cnt), 0);
        chk(t.name, "memwait_cnt", int'(memwait_cnt), 0);
`endif
        // A load in MEM must never be the producer of an EX source.
        if (!t.rst && dut.r_mem.valid && dut.r_mem.load && dut.r_mem.we &&
            dut.r_mem.rd != 5'd0) begin
            bad = dut.r_ex.info.valid &&
                  ((dut.r_ex.use_rs1 && dut.r_ex.rs1 == dut.r_mem.rd) ||
                   (dut.r_ex.use_rs2 && dut.r_ex.rs2 == dut.r_mem.rd));
            chk(t.name, "mem_load_vs_ex_src", int'(bad), 0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_we = 1'b0; id_load = 1'b0;
        br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;

        //                  name          r idv rs1 rs2 u1 u2 rd we ld br mrq rdy ctl   fa fb sc fc mc
        vecs.push_back(v("reset",        1, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, C_RS, 0, 0, 0, 0, 0));
        vecs.push_back(v("t1_add_x1",    0, 1,  2,  3, 1, 1, 1, 1, 0, 0, 0, 0, C_N,  0, 0, 0, 0, 0));
        vecs.push_back(v("t1_sub_x1",    0, 1,  1,  3, 1, 1, 2, 1, 0, 0, 0, 0, C_N,  0, 0, 0, 0, 0));
        vecs.push_back(v("t1_fwd_mem",   0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, C_N,  1, 0, 0, 0, 0));
        vecs.push_back(v("t1_or_x2",     0, 1,  2,  1, 1, 1, 4, 1, 0, 0, 0, 0, C_N,  0, 0, 0, 0, 0));
        vecs.push_back(v("t1_fwd_wb",    0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, C_N,  2, 0, 0, 0, 0));
        vecs.push_back(v("pri_x10a",     0, 1,  0,  0, 0, 0,10, 1, 0, 0, 0, 0, C_N,  0, 0, 0, 0, 0));
        vecs.push_back(v("pri_x10b",     0, 1,  0,  0, 0, 0,10, 1, 0, 0, 0, 0, C_N,  0, 0, 0, 0, 0));
        vecs.push_back(v("pri_rd_x10",   0, 1, 10, 10, 1, 1,11, 1, 0, 0, 0, 0, C_N,  0, 0, 0, 0, 0));
        vecs.push_back(v("pri_mem_wins", 0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, C_N,  1, 1, 0, 0, 0));
        vecs.push_back(v("t2_lw_x5",     0, 1,  6,  0, 1, 0, 5, 1, 1, 0, 0, 0, C_N,  0, 0, 0, 0, 0));
        vecs.push_back(v("t2_load_use",  0, 1,  5,  5, 1, 1, 6, 1, 0, 0, 0, 0, C_LU, 0, 0, 0, 0, 0));
        vecs.push_back(v("t2_retry",     0, 1,  5,  5, 1, 1, 6, 1, 0, 0, 0, 0, C_N,  0, 0, 1, 0, 0));
        vecs.push_back(v("t2_fwd_wb",    0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, C_N,  2, 2, 1, 0, 0));
        vecs.push_back(v("use_lw_x7",    0, 1,  0,  0, 0, 0, 7, 1, 1, 0, 0, 0, C_N,  0, 0, 1, 0, 0));
        vecs.push_back(v("use_unused",   0, 1,  7,  7, 0, 0, 8, 1, 0, 0, 0, 0, C_N,  0, 0, 1, 0, 0));
        vecs.push_back(v("use_nofwd",    0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, C_N,  0, 0, 1, 0, 0));
        vecs.push_back(v("t3_lw_x9",     0, 1,  0,  0, 0, 0, 9, 1, 1, 0, 0, 0, C_N,  0, 0, 1, 0, 0));
        vecs.push_back(v("t3_br_over_lu",0, 1,  0,  9, 0, 1, 3, 1, 0, 1, 0, 0, C_BR, 0, 0, 1, 0, 0));
        vecs.push_back(v("t3_after",     0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, C_N,  0, 0, 1, 1, 0));
        vecs.push_back(v("t4_add_x12",   0, 1,  0,  0, 0, 0,12, 1, 0, 0, 0, 0, C_N,  0, 0, 1, 1, 0));
        vecs.push_back(v("t4_add_x13",   0, 1, 12,  0, 1, 0,13, 1, 0, 0, 0, 0, C_N,  0, 0, 1, 1, 0));
        vecs.push_back(v("t4_wait1",     0, 1,  0,  0, 0, 0,14, 1, 0, 1, 1, 0, C_MW, 1, 0, 1, 1, 0));
        vecs.push_back(v("t4_wait2",     0, 1,  0,  0, 0, 0,14, 1, 0, 1, 1, 0, C_MW, 1, 0, 1, 1, 1));
        vecs.push_back(v("t4_wait3",     0, 1,  0,  0, 0, 0,14, 1, 0, 1, 1, 0, C_MW, 1, 0, 1, 1, 2));
        vecs.push_back(v("t4_ready_br",  0, 1,  0,  0, 0, 0,14, 1, 0, 1, 1, 1, C_BR, 1, 0, 1, 1, 3));
        vecs.push_back(v("t4_after",     0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, C_N,  0, 0, 1, 2, 3));
        vecs.push_back(v("t5_x0a",       0, 1,  0,  0, 0, 0, 0, 1, 0, 0, 0, 0, C_N,  0, 0, 1, 2, 3));
        vecs.push_back(v("t5_x0b",       0, 1,  0,  0, 0, 0, 0, 1, 0, 0, 0, 0, C_N,  0, 0, 1, 2, 3));
        vecs.push_back(v("t5_rd_x0",     0, 1,  0,  0, 1, 1,15, 1, 0, 0, 0, 0, C_N,  0, 0, 1, 2, 3));
        vecs.push_back(v("t5_nofwd",     0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, C_N,  0, 0, 1, 2, 3));
        vecs.push_back(v("t5_lw_x0",     0, 1,  1,  0, 0, 0, 0, 1, 1, 0, 0, 0, C_N,  0, 0, 1, 2, 3));
        vecs.push_back(v("t5_no_lu",     0, 1,  0,  0, 1, 0,16, 1, 0, 0, 0, 0, C_N,  0, 0, 1, 2, 3));
        vecs.push_back(v("t5_nofwd2",    0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, C_N,  0, 0, 1, 2, 3));
        vecs.push_back(v("t6_add_x17",   0, 1,  0,  0, 0, 0,17, 1, 0, 0, 0, 0, C_N,  0, 0, 1, 2, 3));
        vecs.push_back(v("t6_add_x18",   0, 1, 17,  0, 1, 0,18, 1, 0, 0, 0, 0, C_N,  0, 0, 1, 2, 3));
        vecs.push_back(v("t6_wait_sat",  0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 1, 0, C_MW, 1, 0, 1, 2, 3));
        vecs.push_back(v("t6_rst_wait",  1, 0,  0,  0, 0, 0, 0, 0, 0, 0, 1, 0, C_RS, 0, 0, 1, 2, 3));
        vecs.push_back(v("t6_restart",   0, 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, C_N,  0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            run(vecs[i]);
        end

        // Memory wait outranks a pending load-use; the load-use then takes effect
        // the cycle ready arrives, and the retried consumer forwards from WB.
        run(v("h_lw_x20",      0, 1,  0, 0, 0, 0,20, 1, 1, 0, 0, 0, C_N,  0, 0, 0, 0, 0));
        run(v("h_wait_over_lu",0, 1, 20, 0, 1, 0,21, 1, 0, 0, 1, 0, C_MW, 0, 0, 0, 0, 0));
        run(v("h_ready_lu",    0, 1, 20, 0, 1, 0,21, 1, 0, 0, 1, 1, C_LU, 0, 0, 0, 0, 1));
        run(v("h_retry",       0, 1, 20, 0, 1, 0,21, 1, 0, 0, 0, 0, C_N,  0, 0, 1, 0, 1));
        run(v("h_fwd_wb",      0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_N,  2, 0, 1, 0, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
